// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM states, DM access width codes and the default starvation limit.
package dm_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } dm_width_t;

  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, DMA and DM-port signal bundle for dm_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface dm_arbiter_if #(parameter int AW = 14);

  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_width;
  logic          cpu_sign;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wd;
  logic [31:0]   cpu_pc;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic [31:0]   cpu_rd;

  logic          dma_start;
  logic          dma_we;
  logic [31:0]   dma_base;
  logic [3:0]    dma_len;
  logic [31:0]   dma_wd;
  logic          dma_beat;
  logic [31:0]   dma_rd;
  logic          dma_busy;
  logic          dma_done;

  logic          dm_we;
  logic [1:0]    dm_width;
  logic          dm_sign;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wd;
  logic [31:0]   dm_pc;
  logic [31:0]   dm_rd;

  modport master (
    input  cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wd, cpu_pc,
    output cpu_gnt, cpu_stall, cpu_rd,
    input  dma_start, dma_we, dma_base, dma_len, dma_wd,
    output dma_beat, dma_rd, dma_busy, dma_done,
    output dm_we, dm_width, dm_sign, dm_addr, dm_wd, dm_pc,
    input  dm_rd
  );

  modport slave (
    output cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wd, cpu_pc,
    input  cpu_gnt, cpu_stall, cpu_rd,
    output dma_start, dma_we, dma_base, dma_len, dma_wd,
    input  dma_beat, dma_rd, dma_busy, dma_done,
    input  dm_we, dm_width, dm_sign, dm_addr, dm_wd, dm_pc,
    output dm_rd
  );

endinterface

// File: rtl/dm_arbiter_dma_addr_gen.sv
// DMA burst address/beat counter: load latches a word-aligned base and len+1 beats,
// each step advances the address by 4 (wrapping in AW bits) and counts one beat down.
module dma_addr_gen #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [AW-3:0] i_base_w,
  input  logic [3:0]    i_len,
  input  logic          i_step,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [4:0]    r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= {i_base_w, 2'b00};
      r_cnt  <= {1'b0, i_len} + 5'd1;
    end else if (i_step) begin
      r_addr <= r_addr + AW'(4);
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_cnt == 5'd1);

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, a DMA burst is forced ahead
// once it has been denied MAX_WAIT cycles in a row. Grant and DM mux are combinational.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int AW       = 14
) (
  input  logic clk,
  input  logic reset,
  dm_arbiter_if.master bus
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_nxt;
  logic          r_done, w_done_nxt;
  logic          r_dma_we, w_dma_we_nxt;
  logic          w_load;
  logic          w_busy;
  logic          w_dma_pri;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic          w_last;
  logic [AW-1:0] w_dma_addr;
  logic          w_unused;

  assign w_unused  = ^{bus.cpu_addr[31:AW], bus.dma_base[31:AW], bus.dma_base[1:0]};

  assign w_busy    = (r_state == BURST);
  assign w_dma_pri = w_busy && (r_wait_cnt == WW'(MAX_WAIT));
  assign w_cpu_gnt = bus.cpu_req && !w_dma_pri;
  assign w_dma_gnt = w_busy && !w_cpu_gnt;

  dma_addr_gen #(.AW(AW)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_base_w (bus.dma_base[AW-1:2]),
    .i_len    (bus.dma_len),
    .i_step   (w_dma_gnt),
    .o_addr   (w_dma_addr),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_dma_we   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_done     <= w_done_nxt;
      r_dma_we   <= w_dma_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_done_nxt   = 1'b0;
    w_dma_we_nxt = r_dma_we;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_wait_nxt = '0;
        // A start landing on the done pulse is dropped so bursts never chain back-to-back.
        if (bus.dma_start && !r_done) begin
          w_load       = 1'b1;
          w_dma_we_nxt = bus.dma_we;
          w_state_nxt  = BURST;
        end
      end
      BURST: begin
        if (w_dma_gnt) begin
          w_wait_nxt = '0;
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (r_wait_cnt != WW'(MAX_WAIT)) begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_gnt   = w_cpu_gnt;
    bus.cpu_stall = bus.cpu_req && !w_cpu_gnt;
    bus.cpu_rd    = '0;
    bus.dma_beat  = w_dma_gnt;
    bus.dma_rd    = '0;
    bus.dma_busy  = w_busy;
    bus.dma_done  = r_done;
    bus.dm_we     = 1'b0;
    bus.dm_width  = W_BYTE;
    bus.dm_sign   = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wd     = '0;
    bus.dm_pc     = '0;
    if (w_cpu_gnt) begin
      // Reset must never commit a store, even though the CPU keeps its grant.
      bus.dm_we    = bus.cpu_we && reset;
      bus.dm_width = bus.cpu_width;
      bus.dm_sign  = bus.cpu_sign;
      bus.dm_addr  = bus.cpu_addr[AW-1:0];
      bus.dm_wd    = bus.cpu_wd;
      bus.dm_pc    = bus.cpu_pc;
      bus.cpu_rd   = bus.dm_rd;
    end else if (w_dma_gnt) begin
      bus.dm_we    = r_dma_we;
      bus.dm_width = W_WORD;
      bus.dm_addr  = w_dma_addr;
      bus.dm_wd    = bus.dma_wd;
      bus.dma_rd   = bus.dm_rd;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: CPU-only vector table, then DMA burst, starvation,
// wrap, ignored-start and mid-burst-reset sequences.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int AW = 14;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dm_arbiter_if #(.AW(AW)) bus ();

  dm_arbiter #(.MAX_WAIT(4), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        req, we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr, wd, pc, rd;
    logic        e_gnt, e_stall, e_we;
    logic [31:0] e_addr;
    logic [1:0]  e_width;
    logic        e_sign;
    logic [31:0] e_wd, e_pc, e_rd;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dma(input logic we, input logic [31:0] base, input logic [3:0] len);
    bus.dma_start = 1'b1;
    bus.dma_we    = we;
    bus.dma_base  = base;
    bus.dma_len   = len;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_4010, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0,
              1'b1, 1'b0, 1'b1, 32'h0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0};
    vt[1] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h1234_5673, 32'h0, 32'h0000_2004, 32'h0000_0080,
              1'b1, 1'b0, 1'b0, 32'h1673, 2'd0, 1'b1, 32'h0, 32'h0000_2004, 32'h0000_0080};
    vt[2] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0000_3000, 32'hABCD_1234,
              1'b1, 1'b0, 1'b0, 32'h3FFE, 2'd1, 1'b0, 32'h0, 32'h0000_3000, 32'hABCD_1234};
    vt[3] = '{1'b0, 1'b1, 2'd2, 1'b1, 32'h0000_0044, 32'h55, 32'h66, 32'h77,
              1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0};

    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_width = W_WORD; bus.cpu_sign = 1'b0;
    bus.cpu_addr = 32'h40; bus.cpu_wd = 32'h1; bus.cpu_pc = 32'h0;
    bus.dma_start = 1'b0; bus.dma_we = 1'b0; bus.dma_base = 32'h0; bus.dma_len = 4'd0;
    bus.dma_wd = 32'h0; bus.dm_rd = 32'h0;

    // Reset state: CPU keeps its grant, no store reaches DM
    #1;
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst_busy", 32'(bus.dma_busy), 32'd0);
    chk("rst_done", 32'(bus.dma_done), 32'd0);
    chk("rst_beat", 32'(bus.dma_beat), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick();
      bus.cpu_req = vt[i].req; bus.cpu_we = vt[i].we; bus.cpu_width = vt[i].width;
      bus.cpu_sign = vt[i].sign; bus.cpu_addr = vt[i].addr; bus.cpu_wd = vt[i].wd;
      bus.cpu_pc = vt[i].pc; bus.dm_rd = vt[i].rd;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(bus.cpu_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_dm_we", i), 32'(bus.dm_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_dm_addr", i), 32'(bus.dm_addr), vt[i].e_addr);
      chk($sformatf("v%0d_dm_width", i), 32'(bus.dm_width), 32'(vt[i].e_width));
      chk($sformatf("v%0d_dm_sign", i), 32'(bus.dm_sign), 32'(vt[i].e_sign));
      chk($sformatf("v%0d_dm_wd", i), bus.dm_wd, vt[i].e_wd);
      chk($sformatf("v%0d_dm_pc", i), bus.dm_pc, vt[i].e_pc);
      chk($sformatf("v%0d_cpu_rd", i), bus.cpu_rd, vt[i].e_rd);
      chk($sformatf("v%0d_beat", i), 32'(bus.dma_beat), 32'd0);
    end

    // DMA read burst, 4 beats, CPU idle
    tick();
    bus.cpu_req = 1'b0;
    start_dma(1'b0, 32'h0000_0100, 4'd3);
    #1;
    chk("rd_busy_pre", 32'(bus.dma_busy), 32'd0);
    tick();
    bus.dma_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.dm_rd = 32'h1000 + 32'(k);
      #1;
      chk($sformatf("rd_beat%0d", k), 32'(bus.dma_beat), 32'd1);
      chk($sformatf("rd_addr%0d", k), 32'(bus.dm_addr), 32'h100 + 32'(4 * k));
      chk($sformatf("rd_data%0d", k), bus.dma_rd, 32'h1000 + 32'(k));
      chk($sformatf("rd_we%0d", k), 32'(bus.dm_we), 32'd0);
      chk($sformatf("rd_width%0d", k), 32'(bus.dm_width), 32'd2);
      chk($sformatf("rd_done%0d", k), 32'(bus.dma_done), 32'd0);
      tick();
    end
    #1;
    chk("rd_done", 32'(bus.dma_done), 32'd1);
    chk("rd_busy_post", 32'(bus.dma_busy), 32'd0);
    chk("rd_beat_post", 32'(bus.dma_beat), 32'd0);
    tick();
    chk("rd_done_1cyc", 32'(bus.dma_done), 32'd0);

    // Starvation: CPU holds request, DMA forced in after 4 denials
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    bus.dma_wd = 32'hCAFE_0001;
    start_dma(1'b1, 32'h0000_0200, 4'd0);
    #1;
    chk("st_gnt_start", 32'(bus.cpu_gnt), 32'd1);
    tick();
    bus.dma_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("st_gnt%0d", i), 32'(bus.cpu_gnt), 32'd1);
      chk($sformatf("st_beat%0d", i), 32'(bus.dma_beat), 32'd0);
      tick();
    end
    #1;
    chk("st_stall", 32'(bus.cpu_stall), 32'd1);
    chk("st_beat", 32'(bus.dma_beat), 32'd1);
    chk("st_dm_we", 32'(bus.dm_we), 32'd1);
    chk("st_dm_wd", bus.dm_wd, 32'hCAFE_0001);
    chk("st_dm_addr", 32'(bus.dm_addr), 32'h200);
    tick();
    start_dma(1'b0, 32'h0000_0300, 4'd0);
    #1;
    chk("st_done", 32'(bus.dma_done), 32'd1);
    chk("st_gnt_after", 32'(bus.cpu_gnt), 32'd1);
    tick();
    bus.dma_start = 1'b0;
    chk("start_on_done_ignored", 32'(bus.dma_busy), 32'd0);

    // Address wrap, unaligned base forced to word alignment
    bus.cpu_req = 1'b0;
    start_dma(1'b0, 32'h0000_7FFF, 4'd1);
    tick();
    bus.dma_start = 1'b0;
    #1;
    chk("wrap_addr0", 32'(bus.dm_addr), 32'h3FFC);
    tick();
    chk("wrap_addr1", 32'(bus.dm_addr), 32'h0000);
    chk("wrap_beat1", 32'(bus.dma_beat), 32'd1);
    tick();
    chk("wrap_done", 32'(bus.dma_done), 32'd1);

    // Start pulsed mid-burst is ignored
    tick();
    start_dma(1'b0, 32'h0000_0400, 4'd2);
    tick();
    bus.dma_start = 1'b0;
    chk("ign_addr0", 32'(bus.dm_addr), 32'h400);
    tick();
    start_dma(1'b0, 32'h0000_0800, 4'd7);
    #1;
    chk("ign_addr1", 32'(bus.dm_addr), 32'h404);
    tick();
    bus.dma_start = 1'b0;
    chk("ign_addr2", 32'(bus.dm_addr), 32'h408);
    chk("ign_beat2", 32'(bus.dma_beat), 32'd1);
    tick();
    chk("ign_done", 32'(bus.dma_done), 32'd1);
    chk("ign_busy", 32'(bus.dma_busy), 32'd0);

    // Reset after 2 of 8 beats
    tick();
    start_dma(1'b0, 32'h0000_0500, 4'd7);
    tick();
    bus.dma_start = 1'b0;
    chk("mr_addr0", 32'(bus.dm_addr), 32'h500);
    tick();
    chk("mr_addr1", 32'(bus.dm_addr), 32'h504);
    tick();
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    #1;
    chk("mr_busy", 32'(bus.dma_busy), 32'd0);
    chk("mr_beat", 32'(bus.dma_beat), 32'd0);
    chk("mr_dm_we", 32'(bus.dm_we), 32'd0);
    chk("mr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("mr_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1;
    chk("mr_no_done0", 32'(bus.dma_done), 32'd0);
    tick();
    chk("mr_no_done1", 32'(bus.dma_done), 32'd0);
    start_dma(1'b0, 32'h0000_0600, 4'd1);
    tick();
    bus.dma_start = 1'b0;
    chk("mr_new_addr0", 32'(bus.dm_addr), 32'h600);
    tick();
    chk("mr_new_addr1", 32'(bus.dm_addr), 32'h604);
    tick();
    chk("mr_new_done", 32'(bus.dma_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MAX_WAIT, default 4: cycles a pending DMA beat may be denied before it is forced ahead of the CPU.
REQ-002 The block SHALL have parameter AW, default 14: DM byte-address width; every address driven to DM is truncated to AW bits, so it wraps modulo 16384.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port cpu_req, input, 1: Mem-stage access this cycle (load or store).
REQ-006 The block SHALL have ports cpu_we (in, 1), cpu_width (in, 2), cpu_sign (in, 1), cpu_addr (in, 32), cpu_wd (in, 32) and cpu_pc (in, 32): Mem-stage access attributes.
REQ-007 The block SHALL have ports cpu_gnt (out, 1), cpu_stall (out, 1) and cpu_rd (out, 32): grant, pipeline freeze and load data.
REQ-008 The block SHALL have ports dma_start (in, 1), dma_we (in, 1), dma_base (in, 32), dma_len (in, 4, beats-1) and dma_wd (in, 32): burst request and per-beat write data.
REQ-009 The block SHALL have ports dma_beat (out, 1), dma_rd (out, 32), dma_busy (out, 1) and dma_done (out, 1): beat accepted, read data, burst active, completion pulse.
REQ-010 The block SHALL have ports dm_we (out, 1), dm_width (out, 2), dm_sign (out, 1), dm_addr (out, AW), dm_wd (out, 32), dm_pc (out, 32) and dm_rd (in, 32): the single DM port.

Function
REQ-011 The block SHALL allow exactly one DM access per cycle; grant is combinational in the request cycle.
REQ-012 Priority SHALL be as follows: the CPU wins unless dma_busy and wait_cnt==MAX_WAIT, in which case the DMA wins.
REQ-013 cpu_stall SHALL be cpu_req & ~cpu_gnt; the CPU holds its request unchanged while stalled.
REQ-014 The FSM SHALL have states IDLE and BURST; IDLE->BURST on dma_start; BURST->IDLE on the cycle after the last beat.
REQ-015 In IDLE, dma_start SHALL latch base (bits [1:0] forced 0), dma_we and beat count len+1 (1-16).
REQ-016 dma_start while dma_busy SHALL be ignored with no state change.
REQ-017 The DMA beat k address SHALL be base+4k, with width word, sign 0 and dm_pc 0; address increment wraps within AW bits.
REQ-018 When the DMA is granted: dma_beat=1; the beat counter decrements; for a write, dm_wd=dma_wd; for a read, dma_rd=dm_rd in the same cycle.
REQ-019 When the CPU is granted: dm_* SHALL mirror cpu_* (cpu_addr truncated); cpu_rd=dm_rd combinationally.
REQ-020 When neither port is granted: dm_we=0, and the remaining dm_* outputs SHALL be 0.
REQ-021 wait_cnt SHALL increment, saturating at MAX_WAIT, in each BURST cycle where the DMA is not granted; it SHALL clear on any DMA beat and in IDLE.
REQ-022 dma_done SHALL be a one-cycle pulse in the cycle after the final beat, coinciding with dma_busy falling.
REQ-023 dma_busy SHALL be 1 exactly while in BURST.
REQ-024 A dma_start coinciding with dma_done SHALL be ignored; the earliest new start is the following cycle.
REQ-025 When cpu_req=0 in BURST, the DMA SHALL be granted every cycle, giving one beat per cycle.

Reset
REQ-026 Assertion of reset (low) SHALL immediately force: IDLE, dma_busy=0, dma_done=0, dma_beat=0, wait_cnt=0, beat counter=0, dm_we=0.
REQ-027 Reset mid-burst SHALL abandon the remaining beats, with no dma_done pulse.
REQ-028 Combinational cpu_gnt SHALL remain cpu_req during reset, so the CPU is never stalled.

Structure
REQ-029 A shared package SHALL define the state enum (IDLE, BURST), the DM width codes (byte, half, word) and the default MAX_WAIT constant.
REQ-030 The block SHALL contain one natural sub-module, dma_addr_gen: base/beat-counter/address register with wrap, load, step and last outputs.
REQ-031 The grant logic and DM mux SHALL stay in dm_arbiter.

Verification
REQ-032 Scenario: CPU store word to 0x0000_4010, cpu_wd=0xDEADBEEF, no DMA -> cpu_gnt=1, dm_addr=0x0010, dm_we=1, cpu_stall=0.
REQ-033 Scenario: DMA read, base 0x100, len=3, cpu_req=0 -> dma_beat on 4 consecutive cycles at 0x100/0x104/0x108/0x10C, with dma_done one cycle after the last beat.
REQ-034 Scenario: DMA write burst, len=0, with cpu_req held high, MAX_WAIT=4 -> 4 CPU grants, then cpu_stall=1 for one cycle while the DMA beat is written, then dma_done.
REQ-035 Scenario: base 0x3FFC, len=1 -> beat addresses 0x3FFC then 0x0000 (wrap).
REQ-036 Scenario: dma_start pulsed during an active burst -> no effect on the beat count or addresses.
REQ-037 Scenario: reset low after 2 of 8 beats -> dma_busy=0 immediately, no dma_done, and the next dma_start begins a fresh burst from its own base.
